// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the writeback stage: opcode encoding,
// writeback FSM state encoding and the op-class decode.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_SHRA = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WB, ST_WR_HI, ST_WR_LO, ST_MEM_ADDR, ST_MEM_WAIT, ST_LD_WB, ST_BR
  } wb_state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_HILO, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT, OP_SHRA, OP_LDI: c = CLS_ALU;
      OP_MUL, OP_DIV: c = CLS_HILO;
      OP_LD:          c = CLS_LOAD;
      OP_ST:          c = CLS_STORE;
      OP_BR:          c = CLS_BRANCH;
      default:        c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wb_mem_timer.sv
// Memory-wait timeout counter.
//  load    : clear count to 0
//  inc     : count up by one
//  expired : the increment on this edge brings the count to MEM_TIMEOUT,
//            i.e. the current MEM_WAIT cycle is the last one allowed
module wb_mem_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic expired
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)      cnt <= '0;
    else if (load) cnt <= '0;
    else if (inc)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == TMR_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/alu_writeback.sv
// ALU result-retirement stage. Captures the 64-bit result into Z and
// steers it to the regfile, HI/LO, MAR + memory handshake, or PC.
//  in:  clk, clr (async active-low), in_valid, opcode, rc, rdest,
//       br_taken, mdr_in, mem_done
//  out: in_ready, z_hi, z_lo, rf_we/rf_waddr/rf_wdata, hi_we, lo_we,
//       mar_we, mem_rd, mem_wr, pc_we, err
// Every output is a flop loaded from the next-state decode, so strobes
// line up with the state they belong to and nothing is combinational
// from the inputs.
module alu_writeback
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  opcode,
  input  logic [63:0] rc,
  input  logic [3:0]  rdest,
  input  logic        br_taken,
  input  logic [31:0] mdr_in,
  input  logic        mem_done,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        hi_we,
  output logic        lo_we,
  output logic        mar_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        pc_we,
  output logic        err
);

  wb_state_e  state, state_nxt;
  logic [4:0] op_q;
  logic [3:0] rdest_q;
  logic       accept, is_load;
  logic       tmr_load, tmr_inc, tmr_expired;
  logic       illegal, timeout;

  assign accept  = in_valid & in_ready;
  assign is_load = (op_q == OP_LD);

  wb_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(TMR_W)) u_tmr (
    .clk     (clk),
    .clr     (clr),
    .load    (tmr_load),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_inc   = 1'b0;
    illegal   = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: if (accept) begin
        case (op_class(opcode))
          CLS_ALU:               state_nxt = ST_WB;
          CLS_HILO:              state_nxt = ST_WR_HI;
          CLS_LOAD, CLS_STORE:   state_nxt = ST_MEM_ADDR;
          CLS_BRANCH:            state_nxt = ST_BR;
          default:               illegal   = 1'b1;
        endcase
      end
      ST_WR_HI:    state_nxt = ST_WR_LO;
      ST_MEM_ADDR: begin
        state_nxt = ST_MEM_WAIT;
        tmr_load  = 1'b1;
      end
      ST_MEM_WAIT: begin
        tmr_inc = 1'b1;
        // mem_done takes priority over a coincident timeout
        if (mem_done) state_nxt = is_load ? ST_LD_WB : ST_IDLE;
        else if (tmr_expired) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      default:     state_nxt = ST_IDLE;  // WB, WR_LO, LD_WB, BR
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= ST_IDLE;
      z_hi    <= '0;
      z_lo    <= '0;
      op_q    <= '0;
      rdest_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        {z_hi, z_lo} <= rc;
        op_q         <= opcode;
        rdest_q      <= rdest;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      in_ready <= 1'b1;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      hi_we    <= 1'b0;
      lo_we    <= 1'b0;
      mar_we   <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      pc_we    <= 1'b0;
      err      <= 1'b0;
    end else begin
      in_ready <= (state_nxt == ST_IDLE);
      rf_we    <= (state_nxt == ST_WB) || (state_nxt == ST_LD_WB);
      hi_we    <= (state_nxt == ST_WR_HI);
      lo_we    <= (state_nxt == ST_WR_LO);
      mar_we   <= (state_nxt == ST_MEM_ADDR);
      mem_rd   <= (state_nxt == ST_MEM_WAIT) &&  is_load;
      mem_wr   <= (state_nxt == ST_MEM_WAIT) && !is_load;
      // CON result arrives alongside the branch op
      pc_we    <= (state_nxt == ST_BR) && br_taken;
      err      <= illegal | timeout;
      if (state_nxt == ST_WB) begin
        rf_waddr <= rdest;
        rf_wdata <= rc[31:0];
      end else if (state_nxt == ST_LD_WB) begin
        rf_waddr <= rdest_q;
        rf_wdata <= mdr_in;  // captured on the mem_done edge
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [63:0] rc;
  logic [3:0]  rdest;
  logic        br_taken;
  logic [31:0] mdr_in;
  logic        mem_done;
  logic [31:0] z_hi, z_lo;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        hi_we, lo_we, mar_we, mem_rd, mem_wr, pc_we, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_writeback #(.MEM_TIMEOUT(16), .TMR_W(5)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rc(rc), .rdest(rdest), .br_taken(br_taken),
    .mdr_in(mdr_in), .mem_done(mem_done), .z_hi(z_hi), .z_lo(z_lo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_we(hi_we), .lo_we(lo_we), .mar_we(mar_we), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .pc_we(pc_we), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op in the current IDLE cycle; returns 1ns into cycle N+1.
  task automatic issue(input logic [4:0] op, input logic [63:0] r, input logic [3:0] rd);
    opcode = op; rc = r; rdest = rd; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    clr = 1'b0; in_valid = 1'b0; opcode = '0; rc = '0; rdest = '0;
    br_taken = 1'b0; mdr_in = '0; mem_done = 1'b0;
    #3;
    chk("rst_z_hi", z_hi, 0);
    chk("rst_z_lo", z_lo, 0);
    chk("rst_strobes", {rf_we, hi_we, lo_we, mar_we, mem_rd, mem_wr, pc_we, err}, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    tick();
    clr = 1'b1;
    tick();
    chk("idle_ready", in_ready, 1);

    // 1: add
    issue(5'd3, 64'h0000_0000_0000_0007, 4'd5);
    chk("add_z_lo", z_lo, 32'h7);
    chk("add_rf_we", rf_we, 1);
    chk("add_waddr", rf_waddr, 5);
    chk("add_wdata", rf_wdata, 32'h7);
    chk("add_busy", in_ready, 0);
    tick();
    chk("add_rf_we_off", rf_we, 0);
    chk("add_ready_back", in_ready, 1);

    // 2: mul, hi strictly before lo
    issue(5'd15, 64'h0000_0001_FFFF_FFFE, 4'd1);
    chk("mul_hi_lo_n1", {hi_we, lo_we}, 2'b10);
    chk("mul_z_hi", z_hi, 32'h1);
    tick();
    chk("mul_hi_lo_n2", {hi_we, lo_we}, 2'b01);
    chk("mul_z_lo", z_lo, 32'hFFFF_FFFE);
    tick();
    chk("mul_hi_lo_n3", {hi_we, lo_we, in_ready}, 3'b001);

    // 3: ld with mem_done in 3rd wait cycle
    issue(5'd0, 64'h0000_0000_0000_0095, 4'd2);
    chk("ld_mar_we", mar_we, 1);
    chk("ld_z_lo", z_lo, 32'h95);
    chk("ld_no_rd_yet", mem_rd, 0);
    mem_done = 1'b1;  // ignored outside MEM_WAIT
    tick();
    mem_done = 1'b0;
    chk("ld_rd_c1", {mem_rd, mar_we}, 2'b10);
    tick();
    chk("ld_rd_c2", mem_rd, 1);
    tick();
    chk("ld_rd_c3", mem_rd, 1);
    mdr_in = 32'hDEAD_BEEF; mem_done = 1'b1;
    tick();
    mem_done = 1'b0; mdr_in = 32'h0;
    chk("ld_rd_dropped", mem_rd, 0);
    chk("ld_rf_we", rf_we, 1);
    chk("ld_waddr", rf_waddr, 2);
    chk("ld_wdata", rf_wdata, 32'hDEAD_BEEF);
    tick();
    chk("ld_done", {rf_we, in_ready}, 2'b01);

    // 4: st timeout
    issue(5'd2, 64'h0000_0000_0000_0044, 4'd3);
    chk("st_mar_we", mar_we, 1);
    n = 0;
    tick();
    while (mem_wr && n < 40) begin
      n++;
      if (rf_we) chk("st_no_rf_we_wait", rf_we, 0);
      tick();
    end
    chk("st_wr_cycles", n, 16);
    chk("st_err", err, 1);
    chk("st_after", {rf_we, mem_wr, in_ready}, 3'b001);
    tick();
    chk("st_err_pulse", err, 0);

    // 5: br not taken then taken
    br_taken = 1'b0;
    issue(5'd19, 64'h0000_0000_0000_0020, 4'd0);
    chk("br_nt_pc_we", pc_we, 0);
    chk("br_nt_z_lo", z_lo, 32'h20);
    tick();
    br_taken = 1'b1;
    issue(5'd19, 64'h0000_0000_0000_0040, 4'd0);
    chk("br_t_pc_we", pc_we, 1);
    chk("br_t_z_lo", z_lo, 32'h40);
    tick();
    br_taken = 1'b0;
    chk("br_t_pc_we_off", pc_we, 0);

    // 6: illegal opcode
    issue(5'b10100, 64'h0000_0000_0000_0123, 4'd7);
    chk("ill_err", err, 1);
    chk("ill_no_strobes", {rf_we, hi_we, lo_we, mar_we, mem_rd, mem_wr, pc_we}, 0);
    chk("ill_ready", in_ready, 1);
    tick();
    chk("ill_err_pulse", err, 0);

    // async reset in the middle of MEM_WAIT
    issue(5'd0, 64'h0000_0005_0000_0099, 4'd4);
    tick();
    chk("rst_mid_rd_pre", mem_rd, 1);
    #2;
    clr = 1'b0;
    #1;
    chk("rst_mid_rd", mem_rd, 0);
    chk("rst_mid_z", {z_hi, z_lo}, 0);
    tick();
    clr = 1'b1;
    tick();
    chk("rst_mid_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
